// File: rtl/clock_switch_pkg.sv
// clock_switch_pkg: state encoding and helpers shared by the clock switch sequencer
package clock_switch_pkg;

   localparam int MAX_CLOCKS = 32;

   typedef logic [2:0] cs_state_t;

   localparam cs_state_t ST_IDLE           = 3'd0;
   localparam cs_state_t ST_DRAIN          = 3'd1;
   localparam cs_state_t ST_WAIT_OK        = 3'd2;
   localparam cs_state_t ST_SEL_SETTLE     = 3'd3;
   localparam cs_state_t ST_RESTORE_SETTLE = 3'd4;
   localparam cs_state_t ST_DONE           = 3'd5;

   function automatic logic [MAX_CLOCKS-1:0] onehot(input int unsigned idx);
      return MAX_CLOCKS'(1) << idx;
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/clock_switch_ctrl_down_counter.sv
// cs_down_counter: loadable down-counter that holds at zero, shared by all timed states
module cs_down_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] value,
   output logic         zero
);

   assign zero = (value == '0);

   // load wins; otherwise count down and stop at zero
   always_ff @(posedge clk) begin
      if (rst) value <= '0;
      else if (load) value <= load_val;
      else if (!zero) value <= value - 1'b1;
   end

endmodule

// File: rtl/clock_switch_ctrl.sv
// clock_switch_ctrl: safe deselect/drain/confirm/select sequencer for the glitch-free clock mux
module clock_switch_ctrl
   import clock_switch_pkg::*;
#(
   parameter int NUM_CLOCKS     = 2,
   parameter int IDX_W          = 1,
   parameter int RESET_IDX      = 0,
   parameter int DRAIN_CYCLES   = 8,
   parameter int SETTLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   input  logic [IDX_W-1:0]      req_idx,
   output logic                  req_ready,
   input  logic [NUM_CLOCKS-1:0] clk_ok,
   output logic [NUM_CLOCKS-1:0] clk_select,
   output logic [IDX_W-1:0]      cur_idx,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int CNT_W = $clog2(max3(DRAIN_CYCLES, SETTLE_CYCLES, TIMEOUT_CYCLES) + 1);
   localparam logic [CNT_W-1:0] DRAIN_LD   = CNT_W'(DRAIN_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(TIMEOUT_CYCLES - 1);

   cs_state_t             state, nxt;
   logic [IDX_W-1:0]      tgt, prv, cur_nxt;
   logic [NUM_CLOCKS-1:0] sel_nxt;
   logic                  err_nxt, cnt_load, cnt_zero, req_bad;
   logic [CNT_W-1:0]      cnt_val, cnt_q;

   assign req_bad = 32'(req_idx) >= NUM_CLOCKS;

   cs_down_counter #(.W(CNT_W)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (cnt_val),
      .value    (cnt_q),
      .zero     (cnt_zero)
   );

   // next state, next select/index and counter reloads on each state entry
   always_comb begin
      nxt      = state;
      sel_nxt  = clk_select;
      cur_nxt  = cur_idx;
      err_nxt  = 1'b0;
      cnt_load = 1'b0;
      cnt_val  = '0;
      case (state)
         ST_IDLE: if (req_valid) begin
            if (req_bad) begin
               nxt     = ST_DONE;
               err_nxt = 1'b1;
            end else if (req_idx == cur_idx) begin
               nxt = ST_DONE;
            end else begin
               nxt      = ST_DRAIN;
               sel_nxt  = '0;
               cnt_load = 1'b1;
               cnt_val  = DRAIN_LD;
            end
         end
         ST_DRAIN: if (cnt_zero) begin
            nxt      = ST_WAIT_OK;
            cnt_load = 1'b1;
            cnt_val  = TIMEOUT_LD;
         end
         ST_WAIT_OK: if (clk_ok[tgt]) begin
            nxt      = ST_SEL_SETTLE;
            sel_nxt  = NUM_CLOCKS'(onehot(32'(tgt)));
            cnt_load = 1'b1;
            cnt_val  = SETTLE_LD;
         end else if (cnt_zero) begin
            nxt      = ST_RESTORE_SETTLE;
            sel_nxt  = NUM_CLOCKS'(onehot(32'(prv)));
            cnt_load = 1'b1;
            cnt_val  = SETTLE_LD;
         end
         ST_SEL_SETTLE: if (cnt_zero) begin
            nxt     = ST_DONE;
            cur_nxt = tgt;
         end
         ST_RESTORE_SETTLE: if (cnt_zero) begin
            nxt     = ST_DONE;
            err_nxt = 1'b1;
         end
         default: nxt = ST_IDLE;
      endcase
   end

   // register state and every output; request fields are captured on acceptance
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         clk_select <= NUM_CLOCKS'(onehot(RESET_IDX));
         cur_idx    <= IDX_W'(RESET_IDX);
         tgt        <= '0;
         prv        <= '0;
         req_ready  <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         state      <= nxt;
         clk_select <= sel_nxt;
         cur_idx    <= cur_nxt;
         req_ready  <= (nxt == ST_IDLE);
         busy       <= (nxt != ST_IDLE);
         done       <= (nxt == ST_DONE);
         err        <= err_nxt;
         if (state == ST_IDLE && req_valid) begin
            tgt <= req_idx;
            prv <= cur_idx;
         end
      end
   end

endmodule

// File: tb/tb_clock_switch_ctrl.sv
// tb_clock_switch_ctrl: randomized check of two clock switch configurations against a timeline model
module tb_clock_switch_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       rv0, rv1;
   logic       ri0;
   logic [1:0] ri1;
   logic [1:0] ok0;
   logic [2:0] ok1;
   logic [1:0] sel0;
   logic [2:0] sel1;
   logic       cur0;
   logic [1:0] cur1;
   logic       rdy0, rdy1, busy0, busy1, done0, done1, err0, err1;

   int checks = 0;
   int errors = 0;

   int dd[2] = '{8, 2};
   int ss[2] = '{4, 1};
   int tt[2] = '{64, 3};
   int nc[2] = '{2, 3};
   int m_cur[2];
   int m_sel[2];

   clock_switch_ctrl u_dut0 (
      .clk(clk), .rst(rst), .req_valid(rv0), .req_idx(ri0), .req_ready(rdy0),
      .clk_ok(ok0), .clk_select(sel0), .cur_idx(cur0), .busy(busy0), .done(done0), .err(err0)
   );

   clock_switch_ctrl #(
      .NUM_CLOCKS(3), .IDX_W(2), .RESET_IDX(2),
      .DRAIN_CYCLES(2), .SETTLE_CYCLES(1), .TIMEOUT_CYCLES(3)
   ) u_dut1 (
      .clk(clk), .rst(rst), .req_valid(rv1), .req_idx(ri1), .req_ready(rdy1),
      .clk_ok(ok1), .clk_select(sel1), .cur_idx(cur1), .busy(busy1), .done(done1), .err(err1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input int exp);
      checks++;
      if (got !== 32'(exp)) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input int u, input logic v, input int idx, input int ok);
      if (u == 0) begin
         rv0 = v; ri0 = idx[0]; ok0 = ok[1:0];
      end else begin
         rv1 = v; ri1 = idx[1:0]; ok1 = ok[2:0];
      end
   endtask

   task automatic expect_state(input int u, input string tag, input int esel, input int ecur,
                               input int erdy, input int ebsy, input int edn, input int eer);
      chk($sformatf("u%0d %s sel", u, tag), u ? 32'(sel1) : 32'(sel0), esel);
      chk($sformatf("u%0d %s cur", u, tag), u ? 32'(cur1) : 32'(cur0), ecur);
      chk($sformatf("u%0d %s ready", u, tag), u ? 32'(rdy1) : 32'(rdy0), erdy);
      chk($sformatf("u%0d %s busy", u, tag), u ? 32'(busy1) : 32'(busy0), ebsy);
      chk($sformatf("u%0d %s done", u, tag), u ? 32'(done1) : 32'(done0), edn);
      chk($sformatf("u%0d %s err", u, tag), u ? 32'(err1) : 32'(err0), eer);
   endtask

   task automatic reset_models();
      m_cur[0] = 0; m_sel[0] = 1;
      m_cur[1] = 2; m_sel[1] = 4;
   endtask

   task automatic check_reset(input string tag);
      expect_state(0, tag, 1, 0, 1, 0, 0, 0);
      expect_state(1, tag, 4, 2, 1, 0, 0, 0);
   endtask

   // one request: lock = wait cycles before clk_ok[target] rises (>= timeout means never)
   task automatic run_req(input int u, input int idx, input int lock, input bit hold, input int rst_at);
      int d, s, to, n, w, prv, fin_sel, fin_cur, esel, ok;
      bit inval, noop, fail, eflag;
      d = dd[u]; s = ss[u]; to = tt[u];
      prv     = m_cur[u];
      inval   = idx >= nc[u];
      noop    = !inval && idx == prv;
      fail    = !inval && !noop && lock >= to;
      w       = fail ? to : lock + 1;
      n       = (inval || noop) ? 1 : d + w + s + 1;
      eflag   = inval || fail;
      fin_cur = (inval || noop || fail) ? prv : idx;
      fin_sel = (inval || noop) ? m_sel[u] : 1 << fin_cur;
      drive(u, 1'b1, idx, int'($urandom));
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         esel = (inval || noop) ? m_sel[u] : (k <= d + w) ? 0 : fin_sel;
         expect_state(u, "run", esel, (k == n) ? fin_cur : prv, 0, 1, int'(k == n), int'(k == n && eflag));
         if (k == rst_at) begin
            drive(u, 1'b0, 0, 0);
            rst = 1'b1;
            @(negedge clk);
            check_reset("midrst");
            rst = 1'b0;
            reset_models();
            return;
         end
         ok = int'($urandom);
         if (!inval && !noop && k > d)
            ok = (k >= d + lock + 1) ? (ok | (1 << idx)) : (ok & ~(1 << idx));
         drive(u, hold ? 1'b1 : 1'($urandom), int'($urandom), ok);
      end
      @(negedge clk);
      m_cur[u] = fin_cur;
      m_sel[u] = fin_sel;
      expect_state(u, "idle", fin_sel, fin_cur, 1, 0, 0, 0);
      drive(u, hold, int'($urandom), int'($urandom));
   endtask

   // one-hot/zero on both muxes, and a full drain gap between different selects on the default unit
   logic rst_seen = 1'b1;
   int   zeros = 0;
   int   last_nz = 1;
   always @(posedge clk) rst_seen <= rst;
   always @(negedge clk) begin
      chk("onehot0 u0", 32'($onehot0(sel0)), 1);
      chk("onehot0 u1", 32'($onehot0(sel1)), 1);
      if (rst_seen) begin
         zeros = 0;
         last_nz = int'(sel0);
      end else if (sel0 == 2'b00) begin
         zeros++;
      end else begin
         if (int'(sel0) != last_nz) chk("drain gap", 32'(zeros >= dd[0]), 1);
         zeros = 0;
         last_nz = int'(sel0);
      end
   end

   initial begin
      int u, idx, lock;
      rst = 1'b1;
      drive(0, 1'b0, 0, 0);
      drive(1, 1'b0, 0, 0);
      repeat (2) @(negedge clk);
      check_reset("reset");
      rst = 1'b0;
      reset_models();
      run_req(0, 1, 0, 0, 0);
      run_req(0, 0, 0, 0, 0);
      run_req(0, 1, 1000, 0, 0);
      run_req(0, 1, 20, 0, 0);
      run_req(0, 1, 0, 0, 0);
      run_req(0, 0, 63, 0, 0);
      run_req(0, 0, 0, 0, 0);
      run_req(0, 1, 3, 1, 0);
      run_req(0, 0, 0, 0, 0);
      run_req(0, 1, 0, 0, 3);
      run_req(1, 3, 0, 0, 0);
      run_req(1, 2, 0, 0, 0);
      run_req(1, 0, 2, 0, 0);
      run_req(1, 1, 3, 0, 0);
      run_req(1, 1, 0, 0, 0);
      repeat (40) begin
         u    = int'($urandom_range(0, 1));
         idx  = int'($urandom_range(0, u ? 3 : 1));
         lock = int'($urandom_range(0, tt[u] + 2));
         if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            expect_state(u, "gap", m_sel[u], m_cur[u], 1, 0, 0, 0);
         end
         run_req(u, idx, lock, 0, 0);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
